// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// R-type function codes, ALU operation codes and the control-word bundle.
package mips_ctrl_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_JR      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation mapping; valid also serves as the legality
// check for R-type instructions during DECODE.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       valid
);

  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath around one shared ALU:
// fetch, decode, then per-class execute/memory/write-back states.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit SUPPORT_JR = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  logic [3:0] state_q, state_d;
  logic       is_sw_q, is_sw_d;
  logic       illegal_d;
  logic [2:0] fn_alu;
  logic       fn_valid;
  logic       is_jr;
  ctrl_t      ctrl;

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_control (fn_alu),
    .valid       (fn_valid)
  );

  assign is_jr = SUPPORT_JR && (funct == FN_JR);

  // lw/sw is remembered at DECODE so MEMADR never has to look at the IR.
  always_comb begin
    state_d   = S_FETCH;
    is_sw_d   = is_sw_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW: begin
            state_d = S_MEMADR;
            is_sw_d = 1'b0;
          end
          OP_SW: begin
            state_d = S_MEMADR;
            is_sw_d = 1'b1;
          end
          OP_RTYPE: begin
            if (is_jr)         state_d = S_JR;
            else if (fn_valid) state_d = S_EXECUTE;
            else               illegal_d = 1'b1;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: illegal_d = 1'b1;
        endcase
      end
      S_MEMADR:  state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write    = 1'b1;
        ctrl.alu_src_b   = 2'b01;
        ctrl.alu_control = ALU_ADD;
        ctrl.pc_en       = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b   = 2'b11;
        ctrl.alu_control = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = 2'b10;
        ctrl.alu_control = ALU_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_control = fn_alu;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_control = ALU_SUB;
        ctrl.pc_src      = 2'b01;
        ctrl.pc_en       = zero;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src = 2'b10;
        ctrl.pc_en  = 1'b1;
      end
      S_JR: begin
        ctrl.pc_src = 2'b11;
        ctrl.pc_en  = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // During reset present FETCH selects with every enable held low.
    if (reset) begin
      ctrl             = '0;
      ctrl.alu_src_b   = 2'b01;
      ctrl.alu_control = ALU_ADD;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ir_write    = ctrl.ir_write;
  assign mem_write   = ctrl.mem_write;
  assign reg_write   = ctrl.reg_write;
  assign iord        = ctrl.iord;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign reg_dst     = ctrl.reg_dst;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign pc_src      = ctrl.pc_src;
  assign alu_control = ctrl.alu_control;
  assign illegal_op  = illegal_d && !reset && (state_q == S_DECODE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: one DUT with jr support and one without, a scoreboard
// of expected per-cycle state/control words compared one cycle at a time.
`timescale 1ns/1ps
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;

  logic       pc_en0, ir_write0, mem_write0, reg_write0, iord0, mem_to_reg0, reg_dst0, alu_src_a0, illegal_op0;
  logic [1:0] alu_src_b0, pc_src0;
  logic [2:0] alu_control0;
  logic [3:0] state0;
  logic       pc_en1, ir_write1, mem_write1, reg_write1, iord1, mem_to_reg1, reg_dst1, alu_src_a1, illegal_op1;
  logic [1:0] alu_src_b1, pc_src1;
  logic [2:0] alu_control1;
  logic [3:0] state1;

  always #5 clk = ~clk;

  multicycle_control #(.SUPPORT_JR(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en0), .ir_write(ir_write0), .mem_write(mem_write0), .reg_write(reg_write0),
    .iord(iord0), .mem_to_reg(mem_to_reg0), .reg_dst(reg_dst0), .alu_src_a(alu_src_a0),
    .alu_src_b(alu_src_b0), .pc_src(pc_src0), .alu_control(alu_control0),
    .illegal_op(illegal_op0), .state_o(state0)
  );

  multicycle_control #(.SUPPORT_JR(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en1), .ir_write(ir_write1), .mem_write(mem_write1), .reg_write(reg_write1),
    .iord(iord1), .mem_to_reg(mem_to_reg1), .reg_dst(reg_dst1), .alu_src_a(alu_src_a1),
    .alu_src_b(alu_src_b1), .pc_src(pc_src1), .alu_control(alu_control1),
    .illegal_op(illegal_op1), .state_o(state1)
  );

  // Packed order: pc_en ir_write mem_write reg_write iord mem_to_reg reg_dst alu_src_a alu_src_b pc_src alu_control illegal_op
  logic [15:0] outs0, outs1, obs_outs;
  logic [3:0]  obs_state;
  bit          sel = 1'b0;
  assign outs0 = {pc_en0, ir_write0, mem_write0, reg_write0, iord0, mem_to_reg0, reg_dst0, alu_src_a0,
                  alu_src_b0, pc_src0, alu_control0, illegal_op0};
  assign outs1 = {pc_en1, ir_write1, mem_write1, reg_write1, iord1, mem_to_reg1, reg_dst1, alu_src_a1,
                  alu_src_b1, pc_src1, alu_control1, illegal_op1};
  assign obs_outs  = sel ? outs1 : outs0;
  assign obs_state = sel ? state1 : state0;

  localparam logic [15:0] RESET_OUTS = 16'h0044;  // FETCH selects, all enables low

  typedef struct {
    logic [3:0]  st;
    logic [15:0] outs;
  } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn, input bit jr_sup);
    if (op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI || op == OP_J) return 1'b1;
    if (op != OP_RTYPE) return 1'b0;
    if (jr_sup && fn == 6'b001000) return 1'b1;
    return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 || fn == 6'b100101 || fn == 6'b101010;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Reference control word from the state table, using the current inputs.
  function automatic logic [15:0] exp_outs(input logic [3:0] st, input bit jr_sup);
    logic pe, irw, mw, rw, io, m2r, rd, sa, ill;
    logic [1:0] sb_, ps;
    logic [2:0] ac;
    {pe, irw, mw, rw, io, m2r, rd, sa, ill} = '0;
    sb_ = 2'b00; ps = 2'b00; ac = 3'b000;
    case (st)
      S_FETCH:   begin pe = 1; irw = 1; sb_ = 2'b01; ac = 3'b010; end
      S_DECODE:  begin sb_ = 2'b11; ac = 3'b010; ill = !legal(opcode, funct, jr_sup); end
      S_MEMADR:  begin sa = 1; sb_ = 2'b10; ac = 3'b010; end
      S_MEMRD:   io = 1;
      S_MEMWB:   begin m2r = 1; rw = 1; end
      S_MEMWR:   begin io = 1; mw = 1; end
      S_EXECUTE: begin sa = 1; ac = funct_alu(funct); end
      S_ALUWB:   begin rd = 1; rw = 1; end
      S_BRANCH:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = zero; end
      S_ADDIEX:  begin sa = 1; sb_ = 2'b10; ac = 3'b010; end
      S_ADDIWB:  rw = 1;
      S_JUMP:    begin ps = 2'b10; pe = 1; end
      S_JR:      begin ps = 2'b11; pe = 1; end
      default:   ;
    endcase
    return {pe, irw, mw, rw, io, m2r, rd, sa, sb_, ps, ac, ill};
  endfunction

  task automatic push_exp(input logic [3:0] st);
    exp_t e;
    e.st   = st;
    e.outs = exp_outs(st, !sel);
    sb.push_back(e);
  endtask

  task automatic set_ins(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op; funct = fn; zero = z;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (state0 !== S_FETCH || outs0 !== RESET_OUTS) begin
        errors++;
        $display("FAIL reset: state=%0d outs=%h required state=%0d outs=%h", state0, outs0, S_FETCH, RESET_OUTS);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (state0 !== S_FETCH || outs0 !== 16'hC044) begin
      errors++;
      $display("FAIL reset_release: state=%0d outs=%h required state=%0d outs=%h", state0, outs0, S_FETCH, 16'hC044);
    end
    $display("reset: done");
  endtask

  task automatic test_rtype();
    logic [5:0] fns [5] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    exp_t e;
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ins(OP_RTYPE, fns[i], 1'b0);
      push_exp(S_FETCH); push_exp(S_DECODE); push_exp(S_EXECUTE); push_exp(S_ALUWB);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (obs_state !== e.st || obs_outs !== e.outs) begin
          errors++;
          $display("FAIL rtype funct=%b: state=%0d outs=%h required state=%0d outs=%h", fns[i], obs_state, obs_outs, e.st, e.outs);
        end
        @(posedge clk); #1;
      end
      $display("rtype funct=%b: done", fns[i]);
    end
  endtask

  task automatic test_mem();
    exp_t e;
    sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_ins(i == 0 ? OP_LW : OP_SW, 6'h15, 1'b0);
      push_exp(S_FETCH); push_exp(S_DECODE); push_exp(S_MEMADR);
      if (i == 0) begin push_exp(S_MEMRD); push_exp(S_MEMWB); end
      else push_exp(S_MEMWR);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (obs_state !== e.st || obs_outs !== e.outs) begin
          errors++;
          $display("FAIL mem op=%b: state=%0d outs=%h required state=%0d outs=%h", opcode, obs_state, obs_outs, e.st, e.outs);
        end
        @(posedge clk); #1;
      end
      $display("mem op=%b: done", opcode);
    end
  endtask

  task automatic test_branch_jump();
    exp_t e;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin set_ins(OP_BEQ, 6'h00, 1'b1); push_exp(S_FETCH); push_exp(S_DECODE); push_exp(S_BRANCH); end
        1: begin set_ins(OP_BEQ, 6'h00, 1'b0); push_exp(S_FETCH); push_exp(S_DECODE); push_exp(S_BRANCH); end
        2: begin set_ins(OP_J, 6'h3f, 1'b0); push_exp(S_FETCH); push_exp(S_DECODE); push_exp(S_JUMP); end
        default: begin set_ins(OP_ADDI, 6'h2a, 1'b1); push_exp(S_FETCH); push_exp(S_DECODE); push_exp(S_ADDIEX); push_exp(S_ADDIWB); end
      endcase
      while (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (obs_state !== e.st || obs_outs !== e.outs) begin
          errors++;
          $display("FAIL flow op=%b zero=%b: state=%0d outs=%h required state=%0d outs=%h", opcode, zero, obs_state, obs_outs, e.st, e.outs);
        end
        @(posedge clk); #1;
      end
      $display("flow op=%b zero=%b: done", opcode, zero);
    end
  endtask

  // jr on both instances; the two FSMs diverge, so reset re-aligns them.
  task automatic test_jr();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sel = (i == 1);
      set_ins(OP_RTYPE, FN_JR, 1'b0);
      push_exp(S_FETCH); push_exp(S_DECODE);
      if (i == 0) push_exp(S_JR);
      push_exp(S_FETCH);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (obs_state !== e.st || obs_outs !== e.outs) begin
          errors++;
          $display("FAIL jr support=%0d: state=%0d outs=%h required state=%0d outs=%h", !sel, obs_state, obs_outs, e.st, e.outs);
        end
        if (sb.size() != 0) begin @(posedge clk); #1; end
      end
      $display("jr support=%0d: done", !sel);
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0; #1;
    end
    sel = 1'b0;
  endtask

  task automatic test_illegal();
    logic [5:0] ops [3] = '{6'b111111, OP_RTYPE, 6'b000011};
    logic [5:0] fns [3] = '{6'b100000, 6'b000000, 6'b100000};
    exp_t e;
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ins(ops[i], fns[i], 1'b0);
      push_exp(S_FETCH); push_exp(S_DECODE); push_exp(S_FETCH);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (obs_state !== e.st || obs_outs !== e.outs) begin
          errors++;
          $display("FAIL illegal op=%b funct=%b: state=%0d outs=%h required state=%0d outs=%h", ops[i], fns[i], obs_state, obs_outs, e.st, e.outs);
        end
        if (sb.size() != 0) begin @(posedge clk); #1; end
      end
      $display("illegal op=%b funct=%b: done", ops[i], fns[i]);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [4] = '{OP_LW, OP_ADDI, OP_SW, OP_BEQ};
    exp_t e;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ins(ops[i], 6'h00, 1'b1);
      push_exp(S_FETCH); push_exp(S_DECODE);
      case (ops[i])
        OP_LW:   begin push_exp(S_MEMADR); push_exp(S_MEMRD); push_exp(S_MEMWB); end
        OP_SW:   begin push_exp(S_MEMADR); push_exp(S_MEMWR); end
        OP_ADDI: begin push_exp(S_ADDIEX); push_exp(S_ADDIWB); end
        default: push_exp(S_BRANCH);
      endcase
      while (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (obs_state !== e.st || obs_outs !== e.outs) begin
          errors++;
          $display("FAIL b2b op=%b: state=%0d outs=%h required state=%0d outs=%h", ops[i], obs_state, obs_outs, e.st, e.outs);
        end
        @(posedge clk); #1;
      end
      $display("b2b op=%b: done", ops[i]);
    end
  endtask

  task automatic test_reset_in_memwr();
    exp_t e;
    sel = 1'b0;
    set_ins(OP_SW, 6'h00, 1'b0);
    push_exp(S_FETCH); push_exp(S_DECODE); push_exp(S_MEMADR);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (obs_state !== e.st || obs_outs !== e.outs) begin
        errors++;
        $display("FAIL abort_lead: state=%0d outs=%h required state=%0d outs=%h", obs_state, obs_outs, e.st, e.outs);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1; #1;
    checks++;
    if (state0 !== S_MEMWR || outs0 !== RESET_OUTS) begin
      errors++;
      $display("FAIL abort_memwr: state=%0d outs=%h required state=%0d outs=%h", state0, outs0, S_MEMWR, RESET_OUTS);
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (state0 !== S_FETCH || outs0 !== RESET_OUTS) begin
        errors++;
        $display("FAIL abort_hold: state=%0d outs=%h required state=%0d outs=%h", state0, outs0, S_FETCH, RESET_OUTS);
      end
    end
    reset = 1'b0; #1;
    checks++;
    if (state0 !== S_FETCH || pc_en0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_release: state=%0d pc_en=%b required state=%0d pc_en=1", state0, pc_en0, S_FETCH);
    end
    $display("reset in MEMWR: done");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch_jump();
    test_jr();
    test_illegal();
    test_back_to_back();
    test_reset_in_memwr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
